// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 receiver that tracks the W/A/S/D keys and drives a level HID keycode.
// Frames are validated (start, odd parity, stop, timeout) before any decode.
module ps2_keycode_source #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      rx_byte_d;
  logic            strobe_d, err_d;

  logic            clk_meta, clk_sync, clk_prev, data_meta, data_sync;
  logic            fall;

  logic [3:0]      mask_q, mask_d;
  logic            brk_q, brk_d, ext_q, ext_d;
  logic [7:0]      recent_q, recent_d;
  logic            key_hit;
  logic [1:0]      key_idx;
  logic [7:0]      key_hid;
  logic [3:0]      remain;

  // Lines idle high, so the synchronisers reset high to avoid a phantom edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rx_byte_d = rx_byte;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    tmo_cnt_d = (fall || state_q == StIdle) ? '0 : tmo_cnt_q + 1'b1;
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_sync) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_sync;
          state_d  = StStop;
        end
        StStop: begin
          if (data_sync && ((^shift_q) ^ parity_q)) begin
            rx_byte_d = shift_q;
            strobe_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_cnt_q == TimeoutLast) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  // Mask bit index doubles as release-fallback priority: S, A, D, W.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 2'd0;
    key_hid = 8'h00;
    unique case (rx_byte)
      8'h1B: begin key_idx = 2'd0; key_hid = 8'h16; end
      8'h1C: begin key_idx = 2'd1; key_hid = 8'h04; end
      8'h23: begin key_idx = 2'd2; key_hid = 8'h07; end
      8'h1D: begin key_idx = 2'd3; key_hid = 8'h1A; end
      default: key_hit = 1'b0;
    endcase
  end

  function automatic logic [7:0] pick_held(input logic [3:0] m);
    if (m[0])      return 8'h16;
    else if (m[1]) return 8'h04;
    else if (m[2]) return 8'h07;
    else if (m[3]) return 8'h1A;
    else           return 8'h00;
  endfunction

  always_comb begin
    mask_d   = mask_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    recent_d = recent_q;
    remain   = mask_q & ~(4'b0001 << key_idx);
    if (err_d) begin
      // A damaged frame must not leave a prefix armed for the next byte.
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_strobe) begin
      if (rx_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q && key_hit) begin
          if (!brk_q) begin
            mask_d[key_idx] = 1'b1;
            recent_d        = key_hid;
          end else if (mask_q[key_idx]) begin
            mask_d = remain;
            if (recent_q == key_hid) recent_d = pick_held(remain);
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tmo_cnt_q <= '0;
      rx_byte   <= 8'h00;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      mask_q    <= 4'h0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      recent_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_cnt_q <= tmo_cnt_d;
      rx_byte   <= rx_byte_d;
      rx_strobe <= strobe_d;
      frame_err <= err_d;
      mask_q    <= mask_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      recent_q  <= recent_d;
    end
  end

  assign keycode = recent_q;

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Random PS/2 traffic against a key-tracking reference model of ps2_keycode_source.
module tb_ps2_keycode_source;

  localparam int unsigned Tmo = 200;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  ps2_keycode_source #(.TIMEOUT_CYCLES(Tmo)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_ferr = 0;

  always @(negedge Clk) begin
    if (rx_strobe) n_strobe++;
    if (frame_err) n_ferr++;
  end

  // Reference model state: which keys are held, most recent one, prefixes.
  bit        held[4];
  bit        m_brk, m_ext;
  logic [7:0] m_recent, m_rx;
  logic [7:0] codes[4] = '{8'h1B, 8'h1C, 8'h23, 8'h1D};
  logic [7:0] hids[4]  = '{8'h16, 8'h04, 8'h07, 8'h1A};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) held[i] = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_recent = 8'h00;
    m_rx = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    m_rx = b;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      idx = -1;
      for (int i = 0; i < 4; i++) if (codes[i] == b) idx = i;
      if (!m_ext && idx >= 0) begin
        if (!m_brk) begin
          held[idx] = 1'b1;
          m_recent = hids[idx];
        end else if (held[idx]) begin
          held[idx] = 1'b0;
          if (m_recent == hids[idx]) begin
            m_recent = 8'h00;
            for (int j = 3; j >= 0; j--) if (held[j]) m_recent = hids[j];
          end
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b1;
  endtask

  task automatic check_after(input string tag, input int ds, input int de, input int s0,
                             input int e0);
    check_eq({tag, ".strobes"}, n_strobe - s0, ds);
    check_eq({tag, ".errs"}, n_ferr - e0, de);
    check_eq({tag, ".rx_byte"}, rx_byte, m_rx);
    check_eq({tag, ".keycode"}, keycode, m_recent);
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic do_frame(input logic [7:0] b, input int kind);
    int s0, e0;
    logic par;
    s0 = n_strobe;
    e0 = n_ferr;
    par = ~(^b) ^ (kind == 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(kind != 2);
    ps2_data = 1'b1;
    wait_cyc(12);
    if (kind == 0) model_byte(b);
    else begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    check_after($sformatf("frame%0h/k%0d", b, kind), (kind == 0) ? 1 : 0,
                (kind == 0) ? 0 : 1, s0, e0);
  endtask

  task automatic do_timeout();
    int s0, e0;
    s0 = n_strobe;
    e0 = n_ferr;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    wait_cyc(Tmo + 30);
    m_brk = 1'b0;
    m_ext = 1'b0;
    check_after("timeout", 0, 1, s0, e0);
  endtask

  task automatic do_idle_glitch();
    int s0, e0;
    s0 = n_strobe;
    e0 = n_ferr;
    ps2_bit(1'b1);
    wait_cyc(12);
    check_after("idle_edge", 0, 0, s0, e0);
  endtask

  task automatic do_reset_midframe();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check_eq("rst.keycode", keycode, 8'h00);
    check_eq("rst.rx_byte", rx_byte, 8'h00);
    check_eq("rst.rx_strobe", rx_strobe, 1'b0);
    check_eq("rst.frame_err", frame_err, 1'b0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    model_reset();
    wait_cyc(3);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool[8] = '{8'h1B, 8'h1C, 8'h23, 8'h1D, 8'hF0, 8'hF0, 8'hE0, 8'h00};
    logic [7:0] b;
    int r;
    Reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    wait_cyc(5);
    check_eq("reset.keycode", keycode, 8'h00);
    check_eq("reset.rx_byte", rx_byte, 8'h00);
    check_eq("reset.rx_strobe", rx_strobe, 1'b0);
    check_eq("reset.frame_err", frame_err, 1'b0);
    Reset = 1'b0;
    wait_cyc(5);

    do_frame(8'h1C, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h1C, 0);
    do_frame(8'h1C, 0);
    do_frame(8'h23, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h23, 0);
    do_frame(8'h1B, 1);
    do_frame(8'h1B, 0);
    do_timeout();
    do_frame(8'h23, 0);
    do_frame(8'hF0, 0);
    do_timeout();
    do_frame(8'h23, 0);
    do_frame(8'hE0, 0);
    do_frame(8'h1C, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h1D, 2);
    do_frame(8'h1D, 0);
    do_idle_glitch();
    do_reset_midframe();
    do_frame(8'h1C, 0);

    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 99);
      if (r < 5) do_timeout();
      else if (r < 12) do_frame(8'($urandom), 1);
      else if (r < 16) do_frame(8'($urandom), 2);
      else if (r < 19) do_idle_glitch();
      else if (r < 21) do_reset_midframe();
      else begin
        b = pool[$urandom_range(0, 7)];
        if (b == 8'h00) b = 8'($urandom);
        do_frame(b, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
